game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
- Per-frame game controller for the diver display.
- Owns the shark and bottle positions and advances them once per video frame.
- Updates objects sequentially through one shared subtract/compare datapath, one object per clock.
- Detects diver/object collisions, counts collected bottles, runs game state IDLE/PLAY/DEAD/WIN and drives the background colour.
- Sits between the VGA timing generator (frame_tick) and the pixel colour mux.

Parameters:
- NUM_OBJ, 4, number of objects; indices 0..1 are sharks, 2..3 are bottles.
- BOTTLE_GOAL, 8, bottles needed to win (fits bottle_cnt width).
- SCR_LEFT, 144, left edge of active area; objects wrap when x would go below it.
- SCR_RIGHT, 784, x value an object reloads to on wrap.
- DIVER_HALF, 5, diver half-size in pixels, both axes.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse at start of vertical blank.
- start_btn  in  1  debounced level; acted on at its rising edge.
- diver_x  in  10  diver centre x, stable during a sweep.
- diver_y  in  10  diver centre y, stable during a sweep.
- obj_x  out  10*NUM_OBJ  packed object centre x; object i at [10i+9:10i].
- obj_y  out  10*NUM_OBJ  packed object centre y (constant after init).
- obj_vis  out  NUM_OBJ  object drawn/active.
- game_state  out  2  00 IDLE, 01 PLAY, 10 DEAD, 11 WIN.
- bottle_cnt  out  4  bottles collected.
- bg_color  out  12  background RGB.
- busy  out  1  high while an update sweep is in progress.

Behaviour:
- Reset values:
  - game_state=IDLE, bottle_cnt=0, busy=0, bg_color=12'h000, obj_vis all 1.
  - Positions from package: (220,135) (440,330) (250,440) (170,200).
- start_btn edge detector: register start_btn and act on a 0->1 transition.
  - IDLE + edge -> PLAY.
  - DEAD/WIN + edge -> IDLE, with positions, obj_vis and bottle_cnt reloaded to reset values in the same cycle.
  - Edge in PLAY is ignored.
- Sweep:
  - Starts on frame_tick in PLAY with busy=0.
  - busy rises next cycle. Object i is processed in sweep cycle i (i=0..NUM_OBJ-1).
  - busy falls after cycle NUM_OBJ-1. State commit happens in cycle NUM_OBJ.
  - Total latency is NUM_OBJ+1 clocks from tick to committed state.
  - frame_tick while busy=1, or while not in PLAY, is dropped.
- Per-object update:
  - Compute nx = x - SPEED[i] in 11-bit arithmetic.
  - If nx < SCR_LEFT: nx = SCR_RIGHT and obj_vis[i] is set to 1 (respawn).
  - x <= nx.
- Collision uses the new nx:
  - Condition: |diver_x - nx| <= DIVER_HALF + HW[i] AND |diver_y - y| <= DIVER_HALF + HH[i].
  - Differences use 11-bit signed arithmetic.
  - Invisible objects never collide.
- Shark hit sets a sticky hit_flag for the sweep.
- Visible bottle hit:
  - obj_vis[i] <= 0.
  - bottle_cnt increments, saturating at BOTTLE_GOAL.
- Commit cycle:
  - hit_flag -> DEAD. Shark hit has priority over reaching BOTTLE_GOAL in the same sweep.
  - Otherwise bottle_cnt==BOTTLE_GOAL -> WIN.
  - Otherwise stay in PLAY.
  - hit_flag is cleared.
- bg_color is registered from the state: IDLE 000, PLAY 0FF, DEAD FF0, WIN 0F0.
- Reset asserted mid-sweep aborts the sweep immediately; all outputs return to reset values.

Optional Feature:
- Macro GAME_LIVES_EN.
- Defined:
  - Adds output lives[1:0], reset and restart value 3.
  - A shark-hit commit decrements lives and stays in PLAY.
  - DEAD is entered only when lives goes 1->0.
  - The hit shark is respawned at SCR_RIGHT.
- Undefined: no lives port; the first shark hit commits to DEAD.

Decomposition:
- Package game_pkg holds:
  - state encodings.
  - Colour constants.
  - Per-object SPEED {3,2,2,1}, HW {10,10,2,2}, HH {5,5,4,4}.
  - Initial position arrays.
  - IS_SHARK mask.
- One natural sub-module, obj_step: combinational shared datapath. It takes x, y, speed and sizes plus the diver position, and returns nx, wrapped and hit.

Test Plan:
- Reset, then start edge, then one frame_tick -> busy high for 4 cycles; committed after 5 cycles; obj_x = {217,438,248,169}; state PLAY.
- Object 0 at x=146, speed 3 -> after sweep x=784, obj_vis[0]=1.
- Diver at (248,440), tick -> bottle 2 hides, bottle_cnt=1; a second tick at the same diver position leaves bottle_cnt=1.
- Diver at (217,135), tick -> shark 0 hit, state DEAD, bg_color=FF0; further ticks leave positions unchanged; start edge -> IDLE with reset positions.
- bottle_cnt=7, sweep with both a bottle hit and a shark hit -> DEAD, not WIN; bottle hit only -> WIN, bg_color=0F0.
- frame_tick repeated while busy -> ignored, exactly one decrement per object; rst asserted mid-sweep -> immediate reset values.

Source files
------------

// File: rtl/game_pkg.sv
// Shared constants, state encodings and per-object tables for the diver game sequencer.
package game_pkg;

  localparam int unsigned NUM_OBJ     = 4;
  localparam int unsigned IDX_W       = $clog2(NUM_OBJ);
  localparam int unsigned COORD_W     = 10;
  localparam int unsigned SPEED_W     = 4;
  localparam int unsigned SIZE_W      = 5;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned COLOR_W     = 12;
  localparam int unsigned LIVES_W     = 2;

  localparam int unsigned BOTTLE_GOAL = 8;
  localparam int unsigned SCR_LEFT    = 144;
  localparam int unsigned SCR_RIGHT   = 784;
  localparam int unsigned DIVER_HALF  = 5;
  localparam int unsigned LIVES_INIT  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_DEAD = 2'b10,
    ST_WIN  = 2'b11
  } game_state_e;

  localparam logic [COLOR_W-1:0] COLOR_IDLE = 12'h000;
  localparam logic [COLOR_W-1:0] COLOR_PLAY = 12'h0FF;
  localparam logic [COLOR_W-1:0] COLOR_DEAD = 12'hFF0;
  localparam logic [COLOR_W-1:0] COLOR_WIN  = 12'h0F0;

  // Element 0 is the rightmost entry of each concatenation.
  localparam logic [NUM_OBJ-1:0][SPEED_W-1:0] SPEED  = {4'd1, 4'd2, 4'd2, 4'd3};
  localparam logic [NUM_OBJ-1:0][SIZE_W-1:0]  HW     = {5'd2, 5'd2, 5'd10, 5'd10};
  localparam logic [NUM_OBJ-1:0][SIZE_W-1:0]  HH     = {5'd4, 5'd4, 5'd5, 5'd5};
  localparam logic [NUM_OBJ-1:0][COORD_W-1:0] INIT_X = {10'd170, 10'd250, 10'd440, 10'd220};
  localparam logic [NUM_OBJ-1:0][COORD_W-1:0] INIT_Y = {10'd200, 10'd440, 10'd330, 10'd135};
  localparam logic [NUM_OBJ-1:0]              IS_SHARK = 4'b0011;

  // Background colour shown for each game state.
  function automatic logic [COLOR_W-1:0] state_color(input game_state_e s);
    case (s)
      ST_PLAY: state_color = COLOR_PLAY;
      ST_DEAD: state_color = COLOR_DEAD;
      ST_WIN:  state_color = COLOR_WIN;
      default: state_color = COLOR_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/game_sequencer_obj_step.sv
// Shared per-object datapath: moves one object left, wraps it, and tests it against the diver box.
module obj_step
  import game_pkg::*;
(
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [SPEED_W-1:0] speed_i,
  input  logic [SIZE_W-1:0]  hw_i,
  input  logic [SIZE_W-1:0]  hh_i,
  input  logic               vis_i,
  input  logic [COORD_W-1:0] diver_x_i,
  input  logic [COORD_W-1:0] diver_y_i,
  output logic [COORD_W-1:0] nx_o,
  output logic               wrapped_o,
  output logic               hit_o
);

  logic signed [10:0] sub_s;
  logic signed [10:0] dx_s;
  logic signed [10:0] dy_s;
  logic        [10:0] adx;
  logic        [10:0] ady;
  logic        [10:0] lim_x;
  logic        [10:0] lim_y;

  // Move left; anything that would leave the active area respawns at the right edge.
  assign sub_s     = $signed({1'b0, x_i}) - $signed({7'b0, speed_i});
  assign wrapped_o = sub_s < $signed(11'(SCR_LEFT));
  assign nx_o      = wrapped_o ? COORD_W'(SCR_RIGHT) : sub_s[COORD_W-1:0];

  // Box overlap against the new position; a respawning object is visible again.
  assign dx_s  = $signed({1'b0, diver_x_i}) - $signed({1'b0, nx_o});
  assign dy_s  = $signed({1'b0, diver_y_i}) - $signed({1'b0, y_i});
  assign adx   = dx_s[10] ? 11'(-dx_s) : 11'(dx_s);
  assign ady   = dy_s[10] ? 11'(-dy_s) : 11'(dy_s);
  assign lim_x = 11'(DIVER_HALF) + 11'(hw_i);
  assign lim_y = 11'(DIVER_HALF) + 11'(hh_i);
  assign hit_o = (vis_i | wrapped_o) & (adx <= lim_x) & (ady <= lim_y);

endmodule

// File: rtl/game_sequencer.sv
// Per-frame game controller: sequential object sweep, collisions, bottle count and game state.
// Optional macro GAME_LIVES_EN adds a three-life counter and the lives_o port.
module game_sequencer
  import game_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_tick_i,
  input  logic                       start_btn_i,
  input  logic [COORD_W-1:0]         diver_x_i,
  input  logic [COORD_W-1:0]         diver_y_i,
  output logic [NUM_OBJ*COORD_W-1:0] obj_x_o,
  output logic [NUM_OBJ*COORD_W-1:0] obj_y_o,
  output logic [NUM_OBJ-1:0]         obj_vis_o,
  output logic [1:0]                 game_state_o,
  output logic [CNT_W-1:0]           bottle_cnt_o,
  output logic [COLOR_W-1:0]         bg_color_o,
`ifdef GAME_LIVES_EN
  output logic [LIVES_W-1:0]         lives_o,
`endif
  output logic                       busy_o
);

  game_state_e                      state_q;
  logic [NUM_OBJ-1:0][COORD_W-1:0] x_q;
  logic [NUM_OBJ-1:0]              vis_q;
  logic [CNT_W-1:0]                cnt_q;
  logic [CNT_W-1:0]                cnt_d;
  logic [IDX_W-1:0]                idx_q;
  logic                            busy_q;
  logic                            commit_q;
  logic                            hit_q;
  logic                            start_q;
  logic [COLOR_W-1:0]              bg_q;
`ifdef GAME_LIVES_EN
  logic [LIVES_W-1:0]              lives_q;
`endif

  logic                            start_edge;
  logic                            last_obj;
  logic [COORD_W-1:0]              step_nx;
  logic                            step_wrapped;
  logic                            step_hit;

  assign start_edge = start_btn_i & ~start_q;
  assign last_obj   = (idx_q == IDX_W'(NUM_OBJ - 1));
  assign cnt_d      = (cnt_q == CNT_W'(BOTTLE_GOAL)) ? cnt_q : cnt_q + CNT_W'(1);

  // One object per sweep cycle goes through the shared datapath.
  obj_step u_obj_step (
    .x_i       (x_q[idx_q]),
    .y_i       (INIT_Y[idx_q]),
    .speed_i   (SPEED[idx_q]),
    .hw_i      (HW[idx_q]),
    .hh_i      (HH[idx_q]),
    .vis_i     (vis_q[idx_q]),
    .diver_x_i (diver_x_i),
    .diver_y_i (diver_y_i),
    .nx_o      (step_nx),
    .wrapped_o (step_wrapped),
    .hit_o     (step_hit)
  );

  // Game FSM, sweep sequencing and object state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      x_q      <= INIT_X;
      vis_q    <= '1;
      cnt_q    <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      commit_q <= 1'b0;
      hit_q    <= 1'b0;
      start_q  <= 1'b0;
      bg_q     <= COLOR_IDLE;
`ifdef GAME_LIVES_EN
      lives_q  <= LIVES_W'(LIVES_INIT);
`endif
    end else begin
      start_q <= start_btn_i;
      bg_q    <= state_color(state_q);
      case (state_q)
        ST_IDLE: begin
          if (start_edge) state_q <= ST_PLAY;
        end
        ST_PLAY: begin
          if (busy_q) begin
            x_q[idx_q] <= step_nx;
            if (step_wrapped) vis_q[idx_q] <= 1'b1;
            if (step_hit) begin
              if (IS_SHARK[idx_q]) begin
                hit_q <= 1'b1;
`ifdef GAME_LIVES_EN
                x_q[idx_q] <= COORD_W'(SCR_RIGHT);
`endif
              end else begin
                vis_q[idx_q] <= 1'b0;
                cnt_q        <= cnt_d;
              end
            end
            if (last_obj) begin
              busy_q   <= 1'b0;
              commit_q <= 1'b1;
              idx_q    <= '0;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else if (commit_q) begin
            // A tick landing on the commit cycle is dropped so the state settles first.
            commit_q <= 1'b0;
            hit_q    <= 1'b0;
            if (hit_q) begin
`ifdef GAME_LIVES_EN
              if (lives_q == LIVES_W'(1)) begin
                lives_q <= '0;
                state_q <= ST_DEAD;
              end else begin
                lives_q <= lives_q - LIVES_W'(1);
              end
`else
              state_q <= ST_DEAD;
`endif
            end else if (cnt_q == CNT_W'(BOTTLE_GOAL)) begin
              state_q <= ST_WIN;
            end
          end else if (frame_tick_i) begin
            busy_q <= 1'b1;
            idx_q  <= '0;
          end
        end
        default: begin
          // DEAD or WIN: restart reloads the playfield.
          if (start_edge) begin
            state_q <= ST_IDLE;
            x_q     <= INIT_X;
            vis_q   <= '1;
            cnt_q   <= '0;
`ifdef GAME_LIVES_EN
            lives_q <= LIVES_W'(LIVES_INIT);
`endif
          end
        end
      endcase
    end
  end

  assign obj_x_o      = x_q;
  assign obj_y_o      = INIT_Y;
  assign obj_vis_o    = vis_q;
  assign game_state_o = state_q;
  assign bottle_cnt_o = cnt_q;
  assign bg_color_o   = bg_q;
  assign busy_o       = busy_q;
`ifdef GAME_LIVES_EN
  assign lives_o      = lives_q;
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer against a frame-level behavioural model.
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic        start_btn;
  logic [9:0]  diver_x;
  logic [9:0]  diver_y;
  logic [39:0] obj_x;
  logic [39:0] obj_y;
  logic [3:0]  obj_vis;
  logic [1:0]  game_state;
  logic [3:0]  bottle_cnt;
  logic [11:0] bg_color;
  logic        busy;
`ifdef GAME_LIVES_EN
  logic [1:0]  lives;
`endif

  game_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick_i (frame_tick),
    .start_btn_i  (start_btn),
    .diver_x_i    (diver_x),
    .diver_y_i    (diver_y),
    .obj_x_o      (obj_x),
    .obj_y_o      (obj_y),
    .obj_vis_o    (obj_vis),
    .game_state_o (game_state),
    .bottle_cnt_o (bottle_cnt),
    .bg_color_o   (bg_color),
`ifdef GAME_LIVES_EN
    .lives_o      (lives),
`endif
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference tables, written independently of the RTL package.
  int SPD [4] = '{3, 2, 2, 1};
  int HWM [4] = '{10, 10, 2, 2};
  int HHM [4] = '{5, 5, 4, 4};
  int IX  [4] = '{220, 440, 250, 170};
  int IY  [4] = '{135, 330, 440, 200};

  // Model state: 0 IDLE, 1 PLAY, 2 DEAD, 3 WIN.
  int mx [4];
  bit mvis [4];
  int mcnt;
  int mstate;
  int mlives;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int color_of(input int s);
    case (s)
      1:       return 'h0FF;
      2:       return 'hFF0;
      3:       return 'h0F0;
      default: return 'h000;
    endcase
  endfunction

  function automatic int predict_x(input int i);
    int nx;
    nx = mx[i] - SPD[i];
    return (nx < 144) ? 784 : nx;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mx[i]   = IX[i];
      mvis[i] = 1'b1;
    end
    mcnt   = 0;
    mlives = 3;
  endtask

  // One whole frame of game rules applied at once.
  task automatic model_sweep(input int px, input int py);
    bit hit;
    int nx;
    hit = 1'b0;
    if (mstate != 1) return;
    for (int i = 0; i < 4; i++) begin
      nx = mx[i] - SPD[i];
      if (nx < 144) begin
        nx      = 784;
        mvis[i] = 1'b1;
      end
      mx[i] = nx;
      if (mvis[i] && iabs(px - nx) <= 5 + HWM[i] && iabs(py - IY[i]) <= 5 + HHM[i]) begin
        if (i < 2) begin
          hit = 1'b1;
`ifdef GAME_LIVES_EN
          mx[i] = 784;
`endif
        end else begin
          mvis[i] = 1'b0;
          if (mcnt < 8) mcnt++;
        end
      end
    end
    if (hit) begin
`ifdef GAME_LIVES_EN
      if (mlives == 1) begin
        mlives = 0;
        mstate = 2;
      end else begin
        mlives--;
      end
`else
      mstate = 2;
`endif
    end else if (mcnt == 8) begin
      mstate = 3;
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) begin
      v[i] = mvis[i];
      check_eq($sformatf("%s x%0d", tag, i), 64'(obj_x[i*10 +: 10]), 64'(mx[i]));
    end
    check_eq({tag, " vis"}, 64'(obj_vis), 64'(v));
    check_eq({tag, " state"}, 64'(game_state), 64'(mstate));
    check_eq({tag, " cnt"}, 64'(bottle_cnt), 64'(mcnt));
`ifdef GAME_LIVES_EN
    check_eq({tag, " lives"}, 64'(lives), 64'(mlives));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full frame: tick, watch busy, then compare the committed result.
  task automatic frame(input string tag, input int px, input int py, input bit extra);
    bit play;
    play       = (mstate == 1);
    diver_x    = 10'(px);
    diver_y    = 10'(py);
    frame_tick = 1'b1;
    step();
    frame_tick = extra;
    check_eq({tag, " busy_rise"}, 64'(busy), 64'(play));
    step();
    step();
    step();
    frame_tick = 1'b0;
    check_eq({tag, " busy_last"}, 64'(busy), 64'(play));
    step();
    check_eq({tag, " busy_fall"}, 64'(busy), 64'(0));
    step();
    model_sweep(px, py);
    check_all(tag);
    step();
    check_eq({tag, " bg"}, 64'(bg_color), 64'(color_of(mstate)));
  endtask

  task automatic press_start(input string tag);
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    case (mstate)
      0:       mstate = 1;
      2, 3: begin
        mstate = 0;
        model_reset();
      end
      default: ;
    endcase
    check_all(tag);
    step();
    check_eq({tag, " bg"}, 64'(bg_color), 64'(color_of(mstate)));
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, " state"}, 64'(game_state), 64'(0));
    check_eq({tag, " cnt"}, 64'(bottle_cnt), 64'(0));
    check_eq({tag, " busy"}, 64'(busy), 64'(0));
    check_eq({tag, " bg"}, 64'(bg_color), 64'(0));
    check_eq({tag, " vis"}, 64'(obj_vis), 64'('hF));
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("%s x%0d", tag, i), 64'(obj_x[i*10 +: 10]), 64'(IX[i]));
  endtask

  int frames;
  int tgt;

  initial begin
    rst        = 1'b1;
    frame_tick = 1'b0;
    start_btn  = 1'b0;
    diver_x    = '0;
    diver_y    = '0;
    mstate     = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("obj_y%0d", i), 64'(obj_y[i*10 +: 10]), 64'(IY[i]));
    @(negedge clk);
    rst = 1'b0;
    step();

    // Tick in IDLE is dropped.
    frame("idle_tick", 0, 0, 1'b0);
    press_start("start");
    press_start("start_in_play");

    // First frame: bottle 2 collected; second frame at same spot adds nothing.
    frame("bottle1", 248, 440, 1'b0);
    frame("bottle2", 248, 440, 1'b0);

    // Aim at shark 0 until the game ends.
    frames = 0;
    while (mstate == 1 && frames < 8) begin
      frame("shark", predict_x(0), 135, 1'b0);
      frames++;
    end
    check_eq("dead_reached", 64'(game_state), 64'(2));
    frame("dead_tick_a", 300, 300, 1'b0);
    frame("dead_tick_b", 300, 300, 1'b0);
    press_start("restart");
    check_reset_values("restart");
    press_start("replay");

    // Ticks repeated while busy must not cause extra moves.
    frame("retick", 0, 0, 1'b1);

    // Reset in the middle of a sweep.
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    check_reset_values("mid_reset");
    mstate = 0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step();
    press_start("after_reset");

    // Collect bottles while keeping clear of sharks until the game is won.
    frames = 0;
    while (mstate == 1 && frames < 3000) begin
      if (mvis[2] || predict_x(2) == 784) tgt = 2;
      else if (mvis[3] || predict_x(3) == 784) tgt = 3;
      else tgt = -1;
      if (tgt < 0) frame("park", 0, 0, 1'b0);
      else frame("collect", predict_x(tgt), IY[tgt], 1'b0);
      frames++;
    end
    check_eq("win_reached", 64'(game_state), 64'(3));
    check_eq("win_bg", 64'(bg_color), 64'('h0F0));
    frame("win_tick", 0, 0, 1'b0);

    // Random diver positions with automatic restarts.
    for (int k = 0; k < 150; k++) begin
      if (mstate != 1) begin
        press_start("rnd_start");
        if (mstate != 1) press_start("rnd_start2");
      end
      frame("rnd", int'($urandom_range(790, 140)), int'($urandom_range(460, 120)),
            1'($urandom_range(1, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1);
  end

endmodule
